mem_stage: RTL and testbench

- MEM pipeline stage of the MIPS32 core.
- Sits between the EX/MEM register and the MEM/WB register. Executes LB/LW/SB/SW against the data bus with a req/ack handshake and stalls the pipeline while an access is outstanding.
- Produces the data, write-address, write-enable, load-flag, byte-read-enable and HI/LO fields latched by the MEM/WB register.
- Non-memory instructions pass through with zero added latency.

---
 rtl/mem_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: executes LB/LW/SB/SW over a req/ack data bus, stalls while
// an access is outstanding and forms the MEM/WB payload.
module mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  exe_memop,
    input  logic [31:0] exe_wd,
    input  logic [31:0] exe_din,
    input  logic [4:0]  exe_wa,
    input  logic        exe_wreg,
    input  logic        exe_mreg,
    input  logic        exe_whilo,
    input  logic [63:0] exe_hilo,
    output logic [31:0] mem_dreg,
    output logic [4:0]  mem_wa,
    output logic        mem_wreg,
    output logic        mem_mreg,
    output logic [3:0]  dre,
    output logic        mem_whilo,
    output logic [63:0] mem_hilo,
    output logic        stall_req,
    output logic        mem_exc,
    output logic        dbus_req,
    output logic [3:0]  dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    localparam logic [2:0] OP_LB = 3'b001;
    localparam logic [2:0] OP_LW = 3'b010;
    localparam logic [2:0] OP_SB = 3'b101;
    localparam logic [2:0] OP_SW = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              dbus_req_q, dbus_req_d;
    logic [3:0]        dbus_we_q, dbus_we_d;
    logic [31:0]       dbus_addr_q, dbus_addr_d;
    logic [31:0]       dbus_wdata_q, dbus_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              aborted_q, aborted_d;

    // Opcode decode; unlisted codes fall through as non-memory ops.
    logic       is_lb, is_lw, is_sb, is_sw;
    logic       is_load, is_store, is_mem, misaligned;
    logic [3:0] lane_mask, byte_mask;

    always_comb begin
        is_lb      = (exe_memop == OP_LB);
        is_lw      = (exe_memop == OP_LW);
        is_sb      = (exe_memop == OP_SB);
        is_sw      = (exe_memop == OP_SW);
        is_load    = is_lb | is_lw;
        is_store   = is_sb | is_sw;
        is_mem     = is_load | is_store;
        misaligned = (is_lw | is_sw) & (exe_wd[1:0] != 2'b00);
        lane_mask  = 4'b0001 << exe_wd[1:0];
        byte_mask  = (is_lw | is_sw) ? 4'b1111 : lane_mask;
    end

    // Next-state, bus register updates and MEM/WB payload.
    always_comb begin
        state_d      = state_q;
        dbus_req_d   = dbus_req_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_wdata_d = dbus_wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        aborted_d    = aborted_q;

        mem_dreg  = exe_wd;
        mem_wa    = exe_wa;
        mem_wreg  = exe_wreg;
        mem_mreg  = exe_mreg;
        mem_whilo = exe_whilo;
        mem_hilo  = exe_hilo;
        dre       = is_lb ? lane_mask : (is_lw ? 4'b1111 : 4'b0000);
        stall_req = 1'b0;
        mem_exc   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (is_mem && misaligned) begin
                    mem_exc   = 1'b1;
                    mem_wreg  = 1'b0;
                    mem_whilo = 1'b0;
                    dre       = 4'b0000;
                end else if (is_mem) begin
                    stall_req    = 1'b1;
                    mem_wreg     = 1'b0;
                    mem_whilo    = 1'b0;
                    state_d      = BUSY;
                    dbus_req_d   = 1'b1;
                    dbus_we_d    = is_store ? byte_mask : 4'b0000;
                    dbus_addr_d  = {exe_wd[31:2], 2'b00};
                    dbus_wdata_d = is_sb ? {4{exe_din[7:0]}} : exe_din;
                    cnt_d        = '0;
                    aborted_d    = 1'b0;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                mem_wreg  = 1'b0;
                mem_whilo = 1'b0;
                if (dbus_ack) begin
                    rdata_d    = dbus_rdata;
                    dbus_req_d = 1'b0;
                    dbus_we_d  = 4'b0000;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                    // Watchdog: abandon the access; RESP reports the fault.
                    if ((ACK_TIMEOUT != 0) && (cnt_d == TO_W'(ACK_TIMEOUT))) begin
                        dbus_req_d = 1'b0;
                        dbus_we_d  = 4'b0000;
                        aborted_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            RESP: begin
                if (is_load) begin
                    mem_dreg = rdata_q;
                end
                if (aborted_q) begin
                    mem_exc   = 1'b1;
                    mem_wreg  = 1'b0;
                    mem_whilo = 1'b0;
                end
                aborted_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d    = IDLE;
                dbus_req_d = 1'b0;
                dbus_we_d  = 4'b0000;
            end
        endcase

        // Reset dominates every output, including the pass-through fields.
        if (rst) begin
            mem_dreg  = 32'h0;
            mem_wa    = 5'h0;
            mem_wreg  = 1'b0;
            mem_mreg  = 1'b0;
            mem_whilo = 1'b0;
            mem_hilo  = 64'h0;
            dre       = 4'b0000;
            stall_req = 1'b0;
            mem_exc   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 4'b0000;
            dbus_addr_q  <= 32'h0;
            dbus_wdata_q <= 32'h0;
            rdata_q      <= 32'h0;
            cnt_q        <= '0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dbus_req_q   <= dbus_req_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_wdata_q <= dbus_wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            aborted_q    <= aborted_d;
        end
    end

    assign dbus_req   = dbus_req_q & ~rst;
    assign dbus_we    = rst ? 4'b0000 : dbus_we_q;
    assign dbus_addr  = rst ? 32'h0 : dbus_addr_q;
    assign dbus_wdata = rst ? 32'h0 : dbus_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, pass-through, loads, stores, misalignment,
// watchdog timeout and back-to-back accesses.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  exe_memop;
    logic [31:0] exe_wd, exe_din;
    logic [4:0]  exe_wa;
    logic        exe_wreg, exe_mreg, exe_whilo;
    logic [63:0] exe_hilo;
    logic [31:0] mem_dreg;
    logic [4:0]  mem_wa;
    logic        mem_wreg, mem_mreg, mem_whilo;
    logic [3:0]  dre;
    logic [63:0] mem_hilo;
    logic        stall_req, mem_exc, dbus_req;
    logic [3:0]  dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage #(.ACK_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .exe_memop(exe_memop), .exe_wd(exe_wd), .exe_din(exe_din),
        .exe_wa(exe_wa), .exe_wreg(exe_wreg), .exe_mreg(exe_mreg),
        .exe_whilo(exe_whilo), .exe_hilo(exe_hilo),
        .mem_dreg(mem_dreg), .mem_wa(mem_wa), .mem_wreg(mem_wreg),
        .mem_mreg(mem_mreg), .dre(dre), .mem_whilo(mem_whilo),
        .mem_hilo(mem_hilo), .stall_req(stall_req), .mem_exc(mem_exc),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are checked 1-2ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] wd, input logic [31:0] din,
                         input logic [4:0] wa, input logic wreg, input logic mreg,
                         input logic whilo, input logic [63:0] hilo);
        exe_memop = op; exe_wd = wd; exe_din = din; exe_wa = wa;
        exe_wreg = wreg; exe_mreg = mreg; exe_whilo = whilo; exe_hilo = hilo;
    endtask

    task automatic test_reset();
        logic [31:0] any_out;
        rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'h0;
        drive(3'b000, 32'hFFFF_FFFF, 32'h1, 5'd7, 1'b1, 1'b1, 1'b1, 64'hFFFF_0000_FFFF_0000);
        tick(); tick(); #1;
        any_out = mem_dreg | {27'h0, mem_wa} | {31'h0, mem_wreg} | {31'h0, mem_mreg}
                | {28'h0, dre} | {31'h0, mem_whilo} | mem_hilo[31:0] | mem_hilo[63:32]
                | {31'h0, stall_req} | {31'h0, mem_exc} | {31'h0, dbus_req}
                | {28'h0, dbus_we} | dbus_addr | dbus_wdata;
        n_cmp++;
        if (any_out !== 32'h0) begin n_fail++; $display("FAIL reset_init_outputs: or of outputs %h, want 0", any_out); end
        rst = 1'b0;
        drive(3'b010, 32'h0000_0400, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 64'h0);
        tick();
        n_cmp++;
        if (dbus_req !== 1'b1 || stall_req !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy: req %b stall %b, want 1 1", dbus_req, stall_req); end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            any_out = mem_dreg | {27'h0, mem_wa} | {31'h0, mem_wreg} | {31'h0, mem_mreg}
                    | {28'h0, dre} | mem_hilo[31:0] | {31'h0, stall_req} | {31'h0, mem_exc}
                    | {31'h0, dbus_req} | {28'h0, dbus_we} | dbus_addr | dbus_wdata;
            n_cmp++;
            if (any_out !== 32'h0) begin n_fail++; $display("FAIL reset_mid_busy_%0d: or of outputs %h, want 0", i, any_out); end
            tick();
        end
        rst = 1'b0;
        drive(3'b000, 32'h0000_0055, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 64'h0);
        #1;
        n_cmp++;
        if (dbus_req !== 1'b0 || stall_req !== 1'b0 || mem_wreg !== 1'b1 || mem_dreg !== 32'h55)
        begin n_fail++; $display("FAIL reset_release_idle: req %b stall %b wreg %b dreg %h, want 0 0 1 00000055", dbus_req, stall_req, mem_wreg, mem_dreg); end
        tick();
        n_cmp++;
        if (dbus_req !== 1'b0) begin n_fail++; $display("FAIL reset_no_retry: req %b, want 0", dbus_req); end
    endtask

    task automatic test_alu_passthrough();
        drive(3'b000, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 64'hAAAA_AAAA_BBBB_BBBB);
        #1;
        n_cmp++;
        if (mem_dreg !== 32'h1234_5678 || mem_wa !== 5'd5 || mem_wreg !== 1'b1 || mem_whilo !== 1'b1)
        begin n_fail++; $display("FAIL alu_fields: dreg %h wa %0d wreg %b whilo %b, want 12345678 5 1 1", mem_dreg, mem_wa, mem_wreg, mem_whilo); end
        n_cmp++;
        if (mem_hilo !== 64'hAAAA_AAAA_BBBB_BBBB || dre !== 4'b0000 || stall_req !== 1'b0 || mem_exc !== 1'b0)
        begin n_fail++; $display("FAIL alu_ctrl: hilo %h dre %b stall %b exc %b, want aaaaaaaabbbbbbbb 0000 0 0", mem_hilo, dre, stall_req, mem_exc); end
        drive(3'b011, 32'h0000_0101, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 64'h0);
        #1;
        n_cmp++;
        if (stall_req !== 1'b0 || dre !== 4'b0000 || mem_wreg !== 1'b1 || mem_mreg !== 1'b1)
        begin n_fail++; $display("FAIL unknown_op_none: stall %b dre %b wreg %b mreg %b, want 0 0000 1 1", stall_req, dre, mem_wreg, mem_mreg); end
        tick();
        n_cmp++;
        if (dbus_req !== 1'b0) begin n_fail++; $display("FAIL unknown_op_no_bus: req %b, want 0", dbus_req); end
    endtask

    task automatic test_lw_wait();
        int stalls = 0;
        drive(3'b010, 32'h0000_0100, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 64'h0);
        dbus_rdata = 32'hDEAD_BEEF;
        #1;
        stalls += int'(stall_req);
        n_cmp++;
        if (mem_wreg !== 1'b0 || dbus_req !== 1'b0) begin n_fail++; $display("FAIL lw_issue: wreg %b req %b, want 0 0", mem_wreg, dbus_req); end
        tick(); #1;
        stalls += int'(stall_req);
        n_cmp++;
        if (dbus_req !== 1'b1 || dbus_addr !== 32'h100 || dbus_we !== 4'b0000)
        begin n_fail++; $display("FAIL lw_busy1_bus: req %b addr %h we %b, want 1 00000100 0000", dbus_req, dbus_addr, dbus_we); end
        tick();
        dbus_ack = 1'b1;
        #1;
        stalls += int'(stall_req);
        n_cmp++;
        if (dbus_req !== 1'b1 || mem_wreg !== 1'b0) begin n_fail++; $display("FAIL lw_busy2: req %b wreg %b, want 1 0", dbus_req, mem_wreg); end
        tick();
        dbus_ack = 1'b0;
        #1;
        n_cmp++;
        if (stalls !== 3) begin n_fail++; $display("FAIL lw_stall_cycles: %0d, want 3", stalls); end
        n_cmp++;
        if (stall_req !== 1'b0 || mem_dreg !== 32'hDEAD_BEEF || dre !== 4'b1111 || mem_wreg !== 1'b1)
        begin n_fail++; $display("FAIL lw_resp: stall %b dreg %h dre %b wreg %b, want 0 deadbeef 1111 1", stall_req, mem_dreg, dre, mem_wreg); end
        n_cmp++;
        if (dbus_req !== 1'b0 || mem_exc !== 1'b0) begin n_fail++; $display("FAIL lw_resp_bus: req %b exc %b, want 0 0", dbus_req, mem_exc); end
        tick();
        drive(3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_sb();
        drive(3'b101, 32'h0000_0203, 32'h0000_00A5, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0);
        #1;
        n_cmp++;
        if (stall_req !== 1'b1) begin n_fail++; $display("FAIL sb_issue_stall: %b, want 1", stall_req); end
        tick();
        dbus_ack = 1'b1;
        #1;
        n_cmp++;
        if (dbus_req !== 1'b1 || dbus_addr !== 32'h200 || dbus_we !== 4'b1000 || dbus_wdata !== 32'hA5A5_A5A5)
        begin n_fail++; $display("FAIL sb_bus: req %b addr %h we %b wdata %h, want 1 00000200 1000 a5a5a5a5", dbus_req, dbus_addr, dbus_we, dbus_wdata); end
        n_cmp++;
        if (stall_req !== 1'b1) begin n_fail++; $display("FAIL sb_busy_stall: %b, want 1", stall_req); end
        tick();
        dbus_ack = 1'b0;
        #1;
        n_cmp++;
        if (stall_req !== 1'b0 || mem_dreg !== 32'h203 || dre !== 4'b0000 || mem_exc !== 1'b0)
        begin n_fail++; $display("FAIL sb_resp: stall %b dreg %h dre %b exc %b, want 0 00000203 0000 0", stall_req, mem_dreg, dre, mem_exc); end
        n_cmp++;
        if (dbus_req !== 1'b0 || dbus_we !== 4'b0000) begin n_fail++; $display("FAIL sb_resp_bus: req %b we %b, want 0 0000", dbus_req, dbus_we); end
        tick();
        drive(3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_misaligned();
        drive(3'b110, 32'h0000_0102, 32'h1111_2222, 5'd4, 1'b1, 1'b0, 1'b1, 64'h0);
        #1;
        n_cmp++;
        if (mem_exc !== 1'b1 || mem_wreg !== 1'b0 || mem_whilo !== 1'b0 || stall_req !== 1'b0)
        begin n_fail++; $display("FAIL misal_sw: exc %b wreg %b whilo %b stall %b, want 1 0 0 0", mem_exc, mem_wreg, mem_whilo, stall_req); end
        n_cmp++;
        if (dre !== 4'b0000 || mem_dreg !== 32'h102) begin n_fail++; $display("FAIL misal_sw_data: dre %b dreg %h, want 0000 00000102", dre, mem_dreg); end
        tick();
        drive(3'b000, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 64'h0);
        #1;
        n_cmp++;
        if (dbus_req !== 1'b0 || mem_exc !== 1'b0 || stall_req !== 1'b0)
        begin n_fail++; $display("FAIL misal_after: req %b exc %b stall %b, want 0 0 0", dbus_req, mem_exc, stall_req); end
    endtask

    task automatic test_timeout();
        drive(3'b001, 32'h0000_0301, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 64'h0);
        dbus_ack = 1'b0;
        #1;
        n_cmp++;
        if (stall_req !== 1'b1 || dre !== 4'b0010) begin n_fail++; $display("FAIL to_issue: stall %b dre %b, want 1 0010", stall_req, dre); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++;
            if (stall_req !== 1'b1 || dbus_req !== 1'b1 || mem_exc !== 1'b0)
            begin n_fail++; $display("FAIL to_busy_%0d: stall %b req %b exc %b, want 1 1 0", i, stall_req, dbus_req, mem_exc); end
        end
        tick();
        n_cmp++;
        if (mem_exc !== 1'b1 || mem_wreg !== 1'b0 || dbus_req !== 1'b0 || stall_req !== 1'b0)
        begin n_fail++; $display("FAIL to_resp: exc %b wreg %b req %b stall %b, want 1 0 0 0", mem_exc, mem_wreg, dbus_req, stall_req); end
        tick();
        drive(3'b000, 32'h0000_0077, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 64'h0);
        dbus_ack = 1'b1;
        #1;
        n_cmp++;
        if (mem_exc !== 1'b0 || stall_req !== 1'b0 || mem_wreg !== 1'b1 || mem_dreg !== 32'h77)
        begin n_fail++; $display("FAIL to_late_ack: exc %b stall %b wreg %b dreg %h, want 0 0 1 00000077", mem_exc, stall_req, mem_wreg, mem_dreg); end
        tick();
        dbus_ack = 1'b0;
        n_cmp++;
        if (dbus_req !== 1'b0 || mem_exc !== 1'b0) begin n_fail++; $display("FAIL to_late_ack_after: req %b exc %b, want 0 0", dbus_req, mem_exc); end
    endtask

    task automatic test_back_to_back();
        drive(3'b001, 32'h0000_0102, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 64'h0);
        dbus_rdata = 32'h1122_3344;
        tick();
        dbus_ack = 1'b1;
        n_cmp++;
        if (dbus_addr !== 32'h100 || dbus_we !== 4'b0000) begin n_fail++; $display("FAIL b2b_lb_bus: addr %h we %b, want 00000100 0000", dbus_addr, dbus_we); end
        tick();
        dbus_ack = 1'b0;
        #1;
        n_cmp++;
        if (mem_dreg !== 32'h1122_3344 || dre !== 4'b0100 || mem_wreg !== 1'b1 || stall_req !== 1'b0)
        begin n_fail++; $display("FAIL b2b_lb_resp: dreg %h dre %b wreg %b stall %b, want 11223344 0100 1 0", mem_dreg, dre, mem_wreg, stall_req); end
        tick();
        drive(3'b010, 32'h0000_0108, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 64'h0);
        dbus_rdata = 32'h5566_7788;
        #1;
        n_cmp++;
        if (dbus_req !== 1'b0 || stall_req !== 1'b1) begin n_fail++; $display("FAIL b2b_lw_idle: req %b stall %b, want 0 1", dbus_req, stall_req); end
        tick();
        dbus_ack = 1'b1;
        n_cmp++;
        if (dbus_addr !== 32'h108 || dbus_req !== 1'b1) begin n_fail++; $display("FAIL b2b_lw_bus: addr %h req %b, want 00000108 1", dbus_addr, dbus_req); end
        tick();
        dbus_ack = 1'b0;
        #1;
        n_cmp++;
        if (mem_dreg !== 32'h5566_7788 || dre !== 4'b1111 || mem_wa !== 5'd11 || stall_req !== 1'b0)
        begin n_fail++; $display("FAIL b2b_lw_resp: dreg %h dre %b wa %0d stall %b, want 55667788 1111 11 0", mem_dreg, dre, mem_wa, stall_req); end
        tick();
        drive(3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    initial begin
        test_reset();
        test_alu_passthrough();
        test_lw_wait();
        test_sb();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
